// File: rtl/instr_fetch.sv
// Instruction fetch unit: an IDLE/RUN/HALT sequencer feeding a two-stage fetch pipe to the decoder.
// Build option FETCH_PERF_EN adds cycle_cnt_o, a saturating count of RUN-state cycles.
module instr_fetch #(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned START_PC = 0,
  parameter logic [8:0]  HALT_OP  = 9'h1FF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic            stall_i,
  input  logic            branch_i,
  input  logic            jump_abs_i,
  input  logic [15:0]     imm_pc_i,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [8:0]      imem_data_i,
  output logic [8:0]      op_o,
  output logic            op_valid_o,
  output logic [PC_W-1:0] pc_o,
  output logic            done_o
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]     cycle_cnt_o
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state;
  logic [PC_W-1:0] addr_p0;
  logic [PC_W-1:0] pc_p1;
  logic            vld_p1;
  logic [8:0]      skid_p1;
  logic            skid_vld_p1;
  logic [8:0]      op_p2;
  logic [PC_W-1:0] pc_p2;
  logic            vld_p2;
  logic            done;

  logic            take_branch;
  logic            capture;
  logic            hit_halt;
  logic            fill_skid;
  logic            advance;
  logic [8:0]      word_p1;
  logic [PC_W-1:0] addr_next;
  logic [PC_W-1:0] target;
  logic            unused_imm;

  assign unused_imm = ^imm_pc_i;

  always_comb begin
    take_branch = (state == RUN) && vld_p2 && branch_i;
    word_p1     = skid_vld_p1 ? skid_p1 : imem_data_i;
    capture     = (state == RUN) && vld_p1 && !stall_i && !take_branch;
    hit_halt    = capture && (word_p1 == HALT_OP);
    fill_skid   = (state == RUN) && stall_i && !take_branch && vld_p1 && !skid_vld_p1;
    advance     = ((state == IDLE) && start_i) ||
                  ((state == RUN) && !take_branch && !stall_i && !hit_halt);
    addr_next   = addr_p0 + PC_W'(1);
    // Bits of the offset above PC_W cannot reach a PC_W-bit truncated sum.
    target      = jump_abs_i ? imm_pc_i[PC_W-1:0] : pc_p2 + imm_pc_i[PC_W-1:0];
  end

  // p0 -> p1 -> p2: issue address, in-flight fetch, op register presented to the decoder.
  // A stall holds the address, so the in-flight word is parked in the skid register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      addr_p0     <= PC_W'(START_PC);
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      op_p2       <= '0;
      pc_p2       <= '0;
      vld_p2      <= 1'b0;
      done        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state   <= RUN;
            addr_p0 <= addr_next;
            vld_p1  <= 1'b1;
          end
        end
        RUN: begin
          if (take_branch) begin
            addr_p0     <= target;
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            vld_p2      <= 1'b0;
          end else if (stall_i) begin
            if (fill_skid) skid_vld_p1 <= 1'b1;
          end else if (hit_halt) begin
            state       <= HALT;
            done        <= 1'b1;
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            vld_p2      <= 1'b0;
          end else begin
            addr_p0     <= addr_next;
            vld_p1      <= 1'b1;
            skid_vld_p1 <= 1'b0;
            vld_p2      <= capture;
            if (capture) begin
              op_p2 <= word_p1;
              pc_p2 <= pc_p1;
            end
          end
        end
        default: vld_p2 <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (advance)   pc_p1   <= addr_p0;
    if (fill_skid) skid_p1 <= imem_data_i;
  end

  assign imem_addr_o = addr_p0;
  assign op_o        = op_p2;
  assign op_valid_o  = vld_p2;
  assign pc_o        = pc_p2;
  assign done_o      = done;

`ifdef FETCH_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] cycle_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) cycle_cnt <= '0;
    else if (state == RUN) cycle_cnt <= sat_inc(cycle_cnt);
  end

  assign cycle_cnt_o = cycle_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: scoreboarded op stream on a 10-bit-PC instance plus a 4-bit-PC
// instance for address wrap and halt.
module tb_instr_fetch;

  logic        clk;
  logic        reset_n;
  logic        start, stall, branch, jump_abs;
  logic [15:0] imm;
  logic [9:0]  addr;
  logic [8:0]  data;
  logic [8:0]  op;
  logic        op_valid;
  logic [9:0]  pc;
  logic        done;
  logic [15:0] cnt;

  logic        start4;
  logic [3:0]  addr4;
  logic [8:0]  data4;
  logic [8:0]  op4;
  logic        vld4;
  logic [3:0]  pc4;
  logic        done4;
  logic [15:0] cnt4;

  logic [8:0]  mem  [1024];
  logic [8:0]  mem4 [16];

  int n_chk;
  int n_fail;

  typedef struct packed {
    logic [9:0] pc;
    logic [8:0] op;
  } exp_t;

  exp_t sbq[$];

  instr_fetch #(.PC_W(10), .START_PC(0), .HALT_OP(9'h1FF)) dut (
    .clk(clk), .reset_n(reset_n), .start_i(start), .stall_i(stall), .branch_i(branch),
    .jump_abs_i(jump_abs), .imm_pc_i(imm), .imem_addr_o(addr), .imem_data_i(data),
    .op_o(op), .op_valid_o(op_valid), .pc_o(pc), .done_o(done)
`ifdef FETCH_PERF_EN
    , .cycle_cnt_o(cnt)
`endif
  );

  instr_fetch #(.PC_W(4), .START_PC(13), .HALT_OP(9'h1FF)) dut4 (
    .clk(clk), .reset_n(reset_n), .start_i(start4), .stall_i(1'b0), .branch_i(1'b0),
    .jump_abs_i(1'b0), .imm_pc_i(16'h0000), .imem_addr_o(addr4), .imem_data_i(data4),
    .op_o(op4), .op_valid_o(vld4), .pc_o(pc4), .done_o(done4)
`ifdef FETCH_PERF_EN
    , .cycle_cnt_o(cnt4)
`endif
  );

`ifndef FETCH_PERF_EN
  assign cnt  = '0;
  assign cnt4 = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    data  <= mem[addr];
    data4 <= mem4[addr4];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pc(input int p);
    exp_t e;
    e.pc = 10'(p);
    e.op = mem[p];
    sbq.push_back(e);
  endtask

  // An op is consumed when it is valid and either accepted or redirected.
  task automatic cycle();
    exp_t e;
    if (op_valid && (!stall || branch)) begin
      if (sbq.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else begin
        e = sbq.pop_front();
        check("sb_pc", 32'(pc), 32'(e.pc));
        check("sb_op", 32'(op), 32'(e.op));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int p);
    int n = 0;
    while (!(op_valid && pc == p) && n < 20) begin
      cycle();
      n++;
    end
    check("run_to", 32'(op_valid && pc == p), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_op"}, 32'(op), 32'd0);
    check({tag, "_pc"}, 32'(pc), 32'd0);
    check({tag, "_vld"}, 32'(op_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
`ifdef FETCH_PERF_EN
    check({tag, "_cnt"}, 32'(cnt), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  halt_addr;
    logic [15:0] halt_cnt;
    logic [3:0]  epc4;
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b0; start = 1'b0; stall = 1'b0; branch = 1'b0; jump_abs = 1'b0;
    imm = 16'h0; start4 = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = (i < 256) ? 9'(i + 16) : 9'h000;
    mem[8]     = 9'h1FF;
    mem[10'h43] = 9'h1FF;
    for (int i = 0; i < 16; i++) mem4[i] = 9'(9'h100 + i);
    mem4[2] = 9'h1FF;

    repeat (3) @(posedge clk);
    #1;
    check_reset("rst");
    reset_n = 1'b1;
    cycle();
    cycle();
    check("idle_addr", 32'(addr), 32'd0);
    check("idle_vld", 32'(op_valid), 32'd0);

    foreach (sbq[i]) sbq.delete(i);
    for (int p = 0; p <= 5; p++) expect_pc(p);
    for (int p = 3; p <= 7; p++) expect_pc(p);
    for (int p = 16'h40; p <= 16'h42; p++) expect_pc(p);

    start = 1'b1;
    cycle();
    start = 1'b0;
    check("lat_c1_vld", 32'(op_valid), 32'd0);
`ifdef FETCH_PERF_EN
    check("cnt_c1", 32'(cnt), 32'd0);
`endif
    branch = 1'b1; jump_abs = 1'b1; imm = 16'h0040;
    cycle();
    branch = 1'b0; jump_abs = 1'b0; imm = 16'h0;
    check("lat_c2_vld", 32'(op_valid), 32'd1);
`ifdef FETCH_PERF_EN
    check("cnt_c2", 32'(cnt), 32'd1);
`endif
    cycle();
    check("pre_stall_op", 32'(op), 32'h011);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall_op", 32'(op), 32'h011);
      check("stall_pc", 32'(pc), 32'd1);
      check("stall_vld", 32'(op_valid), 32'd1);
    end
    stall = 1'b0;

    run_to(5);
    branch = 1'b1; jump_abs = 1'b0; imm = 16'hFFFE;
    cycle();
    branch = 1'b0; imm = 16'h0;
    check("rel_bub1", 32'(op_valid), 32'd0);
    cycle();
    check("rel_bub2", 32'(op_valid), 32'd0);
    cycle();
    check("rel_pc", 32'(pc), 32'd3);
    check("rel_vld", 32'(op_valid), 32'd1);

    run_to(7);
    branch = 1'b1; stall = 1'b1; jump_abs = 1'b1; imm = 16'h0040;
    cycle();
    branch = 1'b0; stall = 1'b0; jump_abs = 1'b0; imm = 16'h0;
    check("abs_bub1", 32'(op_valid), 32'd0);
    check("abs_nohalt", 32'(done), 32'd0);
    cycle();
    check("abs_bub2", 32'(op_valid), 32'd0);
    check("abs_nohalt2", 32'(done), 32'd0);
    cycle();
    check("abs_pc", 32'(pc), 32'h040);
    check("abs_vld", 32'(op_valid), 32'd1);

    run_to(16'h42);
    cycle();
    check("halt_vld", 32'(op_valid), 32'd0);
    check("halt_done", 32'(done), 32'd1);
    halt_addr = addr;
    halt_cnt = cnt;
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("halt_hold_vld", 32'(op_valid), 32'd0);
      check("halt_hold_done", 32'(done), 32'd1);
      check("halt_hold_addr", 32'(addr), 32'(halt_addr));
      check("halt_hold_pc", 32'(pc), 32'h042);
    end
    start = 1'b0;
`ifdef FETCH_PERF_EN
    check("halt_cnt", 32'(cnt), 32'(halt_cnt));
`endif
    check("sb_drain1", 32'(sbq.size()), 32'd0);

    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check_reset("rst2");
    expect_pc(0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    cycle();
    check("pre_rst_pc", 32'(pc), 32'd1);
    stall = 1'b1;
    cycle();
    reset_n = 1'b0;
    cycle();
    stall = 1'b0;
    reset_n = 1'b1;
    check_reset("rst_stall");
    check("sb_drain2", 32'(sbq.size()), 32'd0);

    start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("w4_lat", 32'(vld4), 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      epc4 = 4'((13 + k) % 16);
      check("w4_vld", 32'(vld4), 32'd1);
      check("w4_pc", 32'(pc4), 32'(epc4));
      check("w4_op", 32'(op4), 32'(mem4[epc4]));
      @(posedge clk); #1;
    end
    for (int k = 0; k < 3; k++) begin
      check("w4_halt_vld", 32'(vld4), 32'd0);
      check("w4_halt_done", 32'(done4), 32'd1);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
